// File: rtl/div_iter_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The master side is the execute stage; the slave side is the divider.
interface div_iter_if;
    logic [66:0] es_to_div_bus;
    logic [32:0] div_to_es_bus;

    modport master (
        output es_to_div_bus,
        input  div_to_es_bus
    );

    modport slave (
        input  es_to_div_bus,
        output div_to_es_bus
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider returning quotient or remainder, 34 cycles from start.
// No backpressure: the result is held and div_ok stays high while the same request is presented.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    div_iter_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef struct packed {
        logic            start;
        logic            use_mod;
        logic            is_unsigned;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
    } req_t;

    typedef struct packed {
        logic            use_mod;
        logic            is_unsigned;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
    } tuple_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    req_t             req;
    tuple_t           cur;
    tuple_t           lat;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  work;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dvs_abs;
    logic [XLEN-1:0]  result;
    logic [XLEN:0]    rem_sh;
    logic [XLEN-1:0]  rem_next;
    logic             q_bit;
    logic             match;
    logic             accept;
    logic             div_ok;
    logic             q_neg;
    logic             r_neg;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  sign_res;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic uns);
        return (!uns && v[XLEN-1]) ? -v : v;
    endfunction

    assign req   = bus.es_to_div_bus;
    assign cur   = {req.use_mod, req.is_unsigned, req.src1, req.src2};
    assign match = (cur == lat);

    // work starts as |dividend| and is shifted out MSB first while quotient bits shift in at the LSB
    assign rem_sh   = {rem, work[XLEN-1]};
    assign q_bit    = (rem_sh >= {1'b0, dvs_abs});
    assign rem_next = q_bit ? (rem_sh[XLEN-1:0] - dvs_abs) : rem_sh[XLEN-1:0];

    always_comb begin
        q_neg   = !lat.is_unsigned && (lat.src1[XLEN-1] ^ lat.src2[XLEN-1]);
        r_neg   = !lat.is_unsigned && lat.src1[XLEN-1];
        quo_fix = q_neg ? -work : work;
        rem_fix = r_neg ? -rem : rem;
        if (lat.src2 == '0) begin
            quo_fix = '1;
            rem_fix = lat.src1;
        end
        sign_res = lat.use_mod ? rem_fix : quo_fix;
    end

    // A differing tuple in DONE restarts exactly like an accept from IDLE
    assign accept = req.start && !flush && ((state == IDLE) || ((state == DONE) && !match));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            lat     <= '0;
            result  <= '0;
            rem     <= '0;
            work    <= '0;
            dvs_abs <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            lat     <= cur;
            work    <= abs_val(req.src1, req.is_unsigned);
            dvs_abs <= abs_val(req.src2, req.is_unsigned);
            rem     <= '0;
            cnt     <= '0;
            state   <= BUSY;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                BUSY: begin
                    if (!req.start) begin
                        state <= IDLE;
                    end else begin
                        rem  <= rem_next;
                        work <= {work[XLEN-2:0], q_bit};
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN - 1)) begin
                            state <= SIGN;
                        end
                    end
                end
                SIGN: begin
                    if (!req.start) begin
                        state <= IDLE;
                    end else begin
                        result <= sign_res;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (!req.start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_ok            = (state == DONE) && req.start && match;
    assign bus.div_to_es_bus = {result, div_ok};

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed scoreboard bench for div_iter against an arithmetic reference model.
module tb_div_iter;
    logic clk;
    logic reset;
    logic flush;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   pushed;
    int   popped;

    typedef struct {
        logic [31:0] val;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    logic        prev_ok;
    logic [31:0] held;

    div_iter_if bus_if();

    div_iter dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] ref_div(input bit m, input bit u, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'h0) return m ? a : 32'hFFFF_FFFF;
        if (u) return m ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'h0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return m ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives a request now; it is sampled at the next rising edge, whose number is returned in t
    task automatic issue(input bit push, input bit m, input bit u, input logic [31:0] a,
                         input logic [31:0] b, output int t);
        exp_t e;
        bus_if.es_to_div_bus = {1'b1, m, u, a, b};
        t = cyc + 1;
        if (push) begin
            e.val = ref_div(m, u, a, b);
            e.t   = t;
            exp_q.push_back(e);
            pushed++;
        end
        #1;
        check32("issue_ok_low", {31'b0, bus_if.div_to_es_bus[0]}, 32'd0);
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (popped != pushed && n < 80) begin
            @(negedge clk);
            n++;
        end
        check32("done_wait", popped, pushed);
    endtask

    task automatic drop;
        step();
        bus_if.es_to_div_bus[66] = 1'b0;
        #1;
        check32("drop_ok_low", {31'b0, bus_if.div_to_es_bus[0]}, 32'd0);
    endtask

    // Monitor: a rising div_ok consumes one expectation; while held high the result must not move
    always @(negedge clk) begin
        logic        ok;
        logic [31:0] res;
        exp_t        e;
        ok  = bus_if.div_to_es_bus[0];
        res = bus_if.div_to_es_bus[32:1];
        if (reset) begin
            prev_ok = 1'b0;
        end else begin
            if (ok && !prev_ok) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ok: got div_ok=1 result %h, expected no completion (cycle %0d)", res, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check32("result", res, e.val);
                    // sample edge T, DONE entered at edge T+33, i.e. first visible in cycle T+34
                    check32("latency", cyc - e.t, 32'd33);
                    held = res;
                    popped++;
                end
            end else if (ok && prev_ok) begin
                check32("hold_result", res, held);
            end
            prev_ok = ok;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        bit          m;
        bit          u;
        logic [31:0] a;
        logic [31:0] b;
        logic [65:0] prev_tup;

        n_checks = 0;
        n_fail   = 0;
        pushed   = 0;
        popped   = 0;
        prev_ok  = 1'b0;
        held     = '0;
        reset    = 1'b1;
        flush    = 1'b0;
        bus_if.es_to_div_bus = '0;
        repeat (3) step();
        @(negedge clk);
        check32("reset_ok", {31'b0, bus_if.div_to_es_bus[0]}, 32'd0);
        check32("reset_result", bus_if.div_to_es_bus[32:1], 32'd0);
        step();
        reset = 1'b0;

        // unsigned 100/7, held in DONE, then switched to the remainder form
        step();
        issue(1, 0, 1, 32'd100, 32'd7, t);
        wait_done();
        repeat (5) begin
            @(negedge clk);
            check32("hold_ok", {31'b0, bus_if.div_to_es_bus[0]}, 32'd1);
        end
        step();
        issue(1, 1, 1, 32'd100, 32'd7, t);
        wait_done();

        // signed -7/2 both forms, via drop then change
        drop();
        step();
        issue(1, 0, 0, 32'hFFFF_FFF9, 32'd2, t);
        wait_done();
        step();
        issue(1, 1, 0, 32'hFFFF_FFF9, 32'd2, t);
        wait_done();

        // divide by zero and signed overflow
        drop();
        step();
        issue(1, 0, 0, 32'h1234_5678, 32'd0, t);
        wait_done();
        step();
        issue(1, 1, 0, 32'h1234_5678, 32'd0, t);
        wait_done();
        step();
        issue(1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, t);
        wait_done();

        // flush mid-operation, then a fresh 50/5 one cycle later
        drop();
        step();
        issue(0, 0, 1, 32'd1000, 32'd3, t);
        while (cyc < t + 9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check32("flush_ok_low", {31'b0, bus_if.div_to_es_bus[0]}, 32'd0);
        issue(1, 0, 1, 32'd50, 32'd5, t);
        wait_done();

        // reset while busy clears the held result
        drop();
        step();
        issue(0, 0, 1, 32'd77, 32'd3, t);
        repeat (8) step();
        reset = 1'b1;
        bus_if.es_to_div_bus[66] = 1'b0;
        step();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check32("rst_busy_result", bus_if.div_to_es_bus[32:1], 32'd0);
            check32("rst_busy_ok", {31'b0, bus_if.div_to_es_bus[0]}, 32'd0);
        end

        // abort in SIGN keeps the previous result
        step();
        issue(1, 0, 1, 32'd50, 32'd5, t);
        wait_done();
        drop();
        step();
        issue(0, 0, 1, 32'd99, 32'd4, t);
        while (cyc < t + 32) step();
        bus_if.es_to_div_bus[66] = 1'b0;
        repeat (40) step();
        check32("abort_sign_result", bus_if.div_to_es_bus[32:1], 32'd10);
        check32("abort_sign_ok", {31'b0, bus_if.div_to_es_bus[0]}, 32'd0);

        // randomized requests, mixing drop-then-issue with in-place tuple changes
        prev_tup = '1;
        for (int i = 0; i < 30; i++) begin
            m = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1 || {m, u, a, b} == prev_tup) drop();
            step();
            issue(1, m, u, a, b, t);
            wait_done();
            prev_tup = {m, u, a, b};
        end

        drop();
        repeat (5) step();
        check32("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit integer divider serving the execute/memory stage. It accepts a division request on `es_to_div_bus` and computes the quotient or remainder with a radix-2 restoring algorithm, one bit per cycle. The result is returned on `div_to_es_bus`, where `div_ok` gates the execute stage's completion. The divider holds its result for as long as the same request is presented, so a stalled execute stage can re-sample it safely.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `flush`  in  1  execute-stage flush (`flush_ES`). Aborts any operation in progress.
- `es_to_div_bus`  in  67  request bus, fields:
  - `[66]` start
  - `[65]` use_mod
  - `[64]` is_unsigned
  - `[63:32]` dividend (src1)
  - `[31:0]` divisor (src2)
- `div_to_es_bus`  out  33  response bus, fields:
  - `[32:1]` div_result
  - `[0]` div_ok

## Operation
- **States:** IDLE, BUSY, SIGN, DONE.
- **Latched request tuple:** {use_mod, is_unsigned, dividend, divisor}. "match" means the current bus tuple equals the latched tuple.
- **IDLE:**
  - start=1 → latch tuple and absolute operand values; clear counter and partial remainder; go BUSY.
  - Absolute values: a signed operand with its MSB set is negated; unsigned operands pass unchanged.
- **BUSY:** one iteration per cycle.
  - rem33 = {rem[31:0], next dividend bit, MSB first}.
  - If rem33 ≥ |divisor|, subtract and shift in quotient bit 1; otherwise shift in 0.
  - Counter 5 bits, 0..31. At counter=31, go SIGN.
- **SIGN:**
  - Quotient is negated when signed and operand signs differ.
  - Remainder takes the dividend's sign.
  - Select quotient or remainder by use_mod; register the result; go DONE.
- **Divisor zero override (applied in SIGN):** quotient = 0xFFFFFFFF, remainder = original dividend. Holds for both signed and unsigned.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0, produced naturally by the algorithm.
- **DONE:**
  - start=1 and match → stay; div_ok=1.
  - start=1 and no match → new request; latch it and go BUSY. This behaves exactly as the IDLE accept.
  - start=0 → go IDLE.
- **div_ok** = (state==DONE) && start && match. This is combinational on the input bus and does not depend on downstream `ready` signals, so no loop forms.
- **div_result** is the registered result. It is 0 after reset and keeps its last value otherwise.
- **Abort:** start=0 while in BUSY or SIGN → IDLE next cycle. No result is written.
- **flush or reset, any state:** IDLE next cycle.
  - Reset also clears the result, latched tuple and counter.
  - Flush clears none of them.
  - Flush has priority over start in the same cycle: no request is accepted.

## Timing
- **Fixed latency:** start sampled in IDLE at edge T.
  - BUSY occupies cycles T+1..T+32.
  - SIGN at T+33.
  - div_ok=1 first in cycle T+34.
- Division by zero and overflow use the same latency; there is no early-out.
- **Requester obligation:** hold the request tuple stable from T until div_ok is seen. A change mid-operation without start=0 is not supported. A change while in DONE is treated as a new request.
- **Back-to-back requests:** a new differing tuple in DONE at cycle D gives div_ok at D+34.
- **Identical consecutive requests:** they return the held result immediately. This is functionally correct.
- **Reset values:** state IDLE, div_ok 0, div_result 0.
- **Throughput:** one division per 34 cycles.

## Test plan
- **Unsigned quotient:** unsigned 100/7 quotient, start held → div_ok rises at T+34, result 14. Repeat with use_mod → result 2.
- **Signed quotient and remainder:** signed -7/2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD. With use_mod → 0xFFFFFFFF.
- **Corner cases:**
  - Divide by zero, signed, dividend 0x12345678 → quotient 0xFFFFFFFF; with use_mod → 0x12345678.
  - Signed 0x80000000 / 0xFFFFFFFF → 0x80000000.
- **Flush mid-operation:** flush at T+10 → div_ok stays 0. A new request 50/5 issued one cycle later → div_ok at that start's sample edge + 34, result 10.
- **Hold, drop and change:**
  - Hold start for 5 cycles in DONE → div_ok stays 1 and the result stays stable.
  - Drop start → IDLE and div_ok=0 the same cycle.
  - Switch the tuple while in DONE → div_ok falls immediately and returns 34 cycles later with the new result.
- **Reset mid-BUSY:** reset in BUSY → IDLE, result 0. An abort via start=0 in SIGN → IDLE, previous result retained.
